// File: rtl/conv_psum_accum_pkg.sv
// Shared types, default widths and arithmetic helpers for the partial-sum accumulator.
package conv_psum_accum_pkg;

    localparam int unsigned NCH_DEF  = 8;
    localparam int unsigned DW_DEF   = 20;
    localparam int unsigned BW_DEF   = 32;
    localparam int unsigned OW_DEF   = 24;
    localparam int unsigned ACCW_DEF = 40;
    localparam int unsigned SHW      = 5;
    localparam int unsigned MATHW    = 64;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } acc_state_t;

    // Intermediate math is done at a width that cannot overflow for any legal ACCW.
    typedef logic signed [MATHW-1:0] wide_t;

    function automatic wide_t sat_clip(input wide_t v, input int unsigned w);
        wide_t mx;
        wide_t mn;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn = -mx - wide_t'(1);
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Round-half-up then arithmetic shift.
    function automatic wide_t round_shift(input wide_t v, input logic [SHW-1:0] sh);
        wide_t r;
        r = v;
        if (sh != '0) r = v + (wide_t'(1) <<< (sh - SHW'(1)));
        return r >>> sh;
    endfunction

endpackage

// File: rtl/psum_add_tree.sv
// Registered pairwise adder tree over NCH signed lanes, with a matching valid/sideband pipe.
module psum_add_tree #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 20,
    parameter int unsigned SBW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid,
    input  logic [NCH*DW-1:0]             data,
    input  logic [SBW-1:0]                sb,
    output logic                          sum_valid,
    output logic [DW+$clog2(NCH)-1:0]     sum,
    output logic [SBW-1:0]                sum_sb
);

    localparam int unsigned L = $clog2(NCH);

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int unsigned IW = DW + s;
        localparam int unsigned NO = NCH >> (s + 1);

        logic [2*NO*IW-1:0]   src;
        logic [NO*(IW+1)-1:0] sum_q;

        if (s == 0) begin : g_in
            assign src = data;
        end else begin : g_chain
            assign src = g_stage[s-1].sum_q;
        end

        // Each pair is sign-extended by one bit so the sum cannot overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else begin
                for (int j = 0; j < NO; j++) begin
                    sum_q[j*(IW+1) +: IW+1] <= {src[(2*j+1)*IW-1], src[2*j*IW +: IW]}
                                             + {src[(2*j+2)*IW-1], src[(2*j+1)*IW +: IW]};
                end
            end
        end
    end

    logic           vld_q [L];
    logic [SBW-1:0] sb_q  [L];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                vld_q[i] <= 1'b0;
                sb_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= valid;
            sb_q[0]  <= sb;
            for (int i = 1; i < L; i++) begin
                vld_q[i] <= vld_q[i-1];
                sb_q[i]  <= sb_q[i-1];
            end
        end
    end

    assign sum       = g_stage[L-1].sum_q;
    assign sum_valid = vld_q[L-1];
    assign sum_sb    = sb_q[L-1];

endmodule

// File: rtl/conv_psum_accum.sv
// Convolution partial-sum accumulator: adder tree, framed accumulate with bias, requantising output.
module conv_psum_accum
    import conv_psum_accum_pkg::*;
#(
    parameter int unsigned NCH  = NCH_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned BW   = BW_DEF,
    parameter int unsigned OW   = OW_DEF,
    parameter int unsigned ACCW = ACCW_DEF
) (
    input  logic                   sclk,
    input  logic                   s_rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [NCH*DW-1:0]      in_data,
    input  logic signed [BW-1:0]   bias,
    input  logic                   bias_enable,
    input  logic [SHW-1:0]         shift,
    input  logic                   relu_en,
    input  logic                   err_clr,
    output logic                   out_valid,
    output logic signed [OW-1:0]   out_data,
    output logic                   out_sat,
    output logic                   seq_err
);

    localparam int unsigned L   = $clog2(NCH);
    localparam int unsigned SW  = DW + L;
    localparam int unsigned SBW = 3 + BW + SHW + 1;

    logic [SBW-1:0]        sb_in;
    logic [SBW-1:0]        t_sb;
    logic                  t_vld;
    logic signed [SW-1:0]  t_sum;
    logic                  t_first, t_last, t_ben, t_relu;
    logic signed [BW-1:0]  t_bias;
    logic [SHW-1:0]        t_shift;

    assign sb_in = {in_first, in_last, bias_enable, bias, shift, relu_en};

    psum_add_tree #(
        .NCH (NCH),
        .DW  (DW),
        .SBW (SBW)
    ) u_tree (
        .clk       (sclk),
        .rst_n     (s_rst_n),
        .valid     (in_valid),
        .data      (in_data),
        .sb        (sb_in),
        .sum_valid (t_vld),
        .sum       (t_sum),
        .sum_sb    (t_sb)
    );

    assign {t_first, t_last, t_ben, t_bias, t_shift, t_relu} = t_sb;

    acc_state_t              state_q, state_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic                    acc_sat_q, acc_sat_d;
    logic                    fire_q, fire_d;
    logic [SHW-1:0]          shf_q, shf_d;
    logic                    relu_q, relu_d;
    logic                    err_set;
    wide_t                   sum_w, start_w, add_w, add_sat;

    // Framing FSM and saturating accumulator; bubbles leave everything untouched.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        fire_d    = 1'b0;
        shf_d     = shf_q;
        relu_d    = relu_q;
        err_set   = 1'b0;
        sum_w     = wide_t'(t_sum);
        start_w   = sum_w + (t_ben ? wide_t'(t_bias) : wide_t'(0));
        add_w     = wide_t'(acc_q) + sum_w;
        add_sat   = sat_clip(add_w, ACCW);
        if (t_vld) begin
            if (t_first) begin
                err_set   = (state_q == ST_ACCUM);
                acc_d     = ACCW'(start_w);
                acc_sat_d = 1'b0;
                state_d   = t_last ? ST_IDLE : ST_ACCUM;
                fire_d    = t_last;
            end else if (state_q == ST_IDLE) begin
                err_set = 1'b1;
            end else begin
                acc_d     = ACCW'(add_sat);
                acc_sat_d = acc_sat_q | (add_sat != add_w);
                if (t_last) begin
                    state_d = ST_IDLE;
                    fire_d  = 1'b1;
                end
            end
            if (fire_d) begin
                shf_d  = t_shift;
                relu_d = t_relu;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            fire_q    <= 1'b0;
            shf_q     <= '0;
            relu_q    <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            fire_q    <= fire_d;
            shf_q     <= shf_d;
            relu_q    <= relu_d;
            if (err_set)      seq_err <= 1'b1;
            else if (err_clr) seq_err <= 1'b0;
        end
    end

    wide_t rnd_w, res_w;

    always_comb begin
        rnd_w = round_shift(wide_t'(acc_q), shf_q);
        if (relu_q && rnd_w[MATHW-1]) rnd_w = '0;
        res_w = sat_clip(rnd_w, OW);
    end

    // Output register; data and flag hold between result pulses.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= fire_q;
            if (fire_q) begin
                out_data <= OW'(res_w);
                out_sat  <= acc_sat_q | (res_w != rnd_w);
            end
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Randomised and directed bench for conv_psum_accum against a behavioural accumulation model.
module tb_conv_psum_accum;

    localparam int NCH  = 8;
    localparam int DW   = 20;
    localparam int BW   = 32;
    localparam int OW   = 24;
    localparam int ACCW = 40;
    localparam int LAT  = 5;

    logic                  sclk = 1'b0;
    logic                  s_rst_n;
    logic                  in_valid, in_first, in_last;
    logic [NCH*DW-1:0]     in_data;
    logic signed [BW-1:0]  bias;
    logic                  bias_enable;
    logic [4:0]            shift;
    logic                  relu_en, err_clr;
    logic                  out_valid;
    logic signed [OW-1:0]  out_data;
    logic                  out_sat, seq_err;

    conv_psum_accum #(
        .NCH(NCH), .DW(DW), .BW(BW), .OW(OW), .ACCW(ACCW)
    ) dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .in_valid    (in_valid),
        .in_first    (in_first),
        .in_last     (in_last),
        .in_data     (in_data),
        .bias        (bias),
        .bias_enable (bias_enable),
        .shift       (shift),
        .relu_en     (relu_en),
        .err_clr     (err_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .seq_err     (seq_err)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        longint data;
        bit     sat;
        longint cyc;
    } exp_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    exp_t   exp_q[$];
    bit     m_open = 1'b0;
    longint m_acc = 0;
    bit     m_sat = 1'b0;
    bit     m_err = 1'b0;
    longint got_data = 0;
    bit     got_sat = 1'b0;
    int     n_out = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, input int w, output bit c);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        c = 1'b0;
        if (v > hi) begin c = 1'b1; return hi; end
        if (v < lo) begin c = 1'b1; return lo; end
        return v;
    endfunction

    // Reference: accumulation framed by first/last, then round, shift, ReLU and clip.
    task automatic model_beat(input bit f, input bit l, input int lanes[NCH], input int b,
                              input bit be, input int sh, input bit rl);
        longint s;
        longint r;
        bit     c;
        exp_t   e;
        s = 0;
        for (int k = 0; k < NCH; k++) s += lanes[k];
        if (f) begin
            if (m_open) m_err = 1'b1;
            m_acc  = s + (be ? longint'(b) : 64'sd0);
            m_sat  = 1'b0;
            m_open = 1'b1;
        end else if (!m_open) begin
            m_err = 1'b1;
            return;
        end else begin
            m_acc = clamp(m_acc + s, ACCW, c);
            if (c) m_sat = 1'b1;
        end
        if (l) begin
            r = m_acc;
            if (sh > 0) r = (r + (64'sd1 <<< (sh - 1))) >>> sh;
            if (rl && r < 0) r = 0;
            r = clamp(r, OW, c);
            e.data = r;
            e.sat  = m_sat | c;
            e.cyc  = cyc + LAT;
            exp_q.push_back(e);
            m_open = 1'b0;
        end
    endtask

    task automatic beat(input bit f, input bit l, input int lanes[NCH], input int b,
                        input bit be, input int sh, input bit rl);
        @(negedge sclk);
        in_valid    = 1'b1;
        in_first    = f;
        in_last     = l;
        bias        = b;
        bias_enable = be;
        shift       = 5'(sh);
        relu_en     = rl;
        for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = DW'(lanes[k]);
        model_beat(f, l, lanes, b, be, sh, rl);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sclk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
            err_clr  = 1'b0;
        end
    endtask

    // Output monitor: every pulse must match the next expected result at the exact cycle.
    always @(negedge sclk) begin
        exp_t e;
        if (!s_rst_n) begin
            got_data = 0;
            got_sat  = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("out_data", out_data, e.data);
                check_val("out_sat", out_sat, e.sat);
                check_val("latency", cyc, e.cyc);
            end
            got_data = out_data;
            got_sat  = out_sat;
            n_out++;
        end else begin
            check_val("hold_data", out_data, got_data);
            check_val("hold_sat", out_sat, got_sat);
        end
    end

    initial begin
        int ln[NCH];
        int n0;
        bit f, l, be, rl;
        int b, sh;

        s_rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
        bias = '0; bias_enable = 1'b0; shift = '0; relu_en = 1'b0; err_clr = 1'b0;
        #12;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_sat", out_sat, 0);
        check_val("rst_seq_err", seq_err, 0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        idle(2);

        ln = '{default: 1};
        beat(1, 1, ln, 10, 1, 0, 0);
        idle(8);
        check_val("single_bias_data", got_data, 18);
        check_val("single_bias_sat", got_sat, 0);

        ln = '{default: 100};
        beat(1, 0, ln, 0, 0, 0, 0); idle(1);
        beat(0, 0, ln, 0, 0, 0, 0); idle(1);
        beat(0, 1, ln, 0, 0, 4, 0);
        idle(8);
        check_val("three_beat_round", got_data, 150);

        ln = '{default: -5};
        beat(1, 1, ln, 0, 0, 0, 0);
        idle(8);
        check_val("neg_no_relu", got_data, -40);
        beat(1, 1, ln, 0, 0, 0, 1);
        idle(8);
        check_val("neg_relu", got_data, 0);

        ln = '{default: 524287};
        beat(1, 0, ln, 0, 0, 0, 0);
        beat(0, 0, ln, 0, 0, 0, 0);
        beat(0, 0, ln, 0, 0, 0, 0);
        beat(0, 1, ln, 0, 0, 0, 0);
        idle(8);
        check_val("ow_clip_data", got_data, 8388607);
        check_val("ow_clip_sat", got_sat, 1);

        n0 = n_out;
        ln = '{default: 1};
        beat(0, 1, ln, 0, 0, 0, 0);
        idle(8);
        check_val("orphan_seq_err", seq_err, 1);
        check_val("orphan_no_out", n_out, n0);
        @(negedge sclk);
        err_clr = 1'b1;
        m_err = 1'b0;
        idle(4);
        check_val("err_clr", seq_err, 0);

        ln = '{default: 3};
        beat(1, 0, ln, 0, 0, 0, 0);
        ln = '{default: 2};
        beat(1, 0, ln, 0, 0, 0, 0);
        ln = '{default: 1};
        beat(0, 1, ln, 0, 0, 0, 0);
        idle(8);
        check_val("restart_seq_err", seq_err, 1);
        check_val("restart_data", got_data, 24);

        ln = '{default: 9};
        beat(1, 0, ln, 0, 0, 0, 0);
        beat(0, 1, ln, 0, 0, 0, 0);
        idle(1);
        #2;
        s_rst_n = 1'b0;
        exp_q.delete();
        m_open = 1'b0;
        m_err  = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_data", out_data, 0);
        check_val("midrst_out_sat", out_sat, 0);
        check_val("midrst_seq_err", seq_err, 0);
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        n0 = n_out;
        idle(10);
        check_val("midrst_no_out", n_out, n0);

        for (int n = 0; n < 400; n++) begin
            f  = m_open ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 7) == 0)
                    ln[k] = ($urandom_range(0, 1) != 0) ? 524287 : -524288;
                else
                    ln[k] = int'($urandom_range(0, 2047)) - 1024;
            end
            b  = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4095)) - 2048;
            be = ($urandom_range(0, 1) != 0);
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            rl = ($urandom_range(0, 1) != 0);
            beat(f, l, ln, b, be, sh, rl);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(10);
        check_val("drain_empty", exp_q.size(), 0);
        check_val("final_seq_err", seq_err, m_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_psum_accum.md
CONV_PSUM_ACCUM -- requirements
Module: conv_psum_accum

Interface
REQ-001 Parameters (name, default, meaning): NCH, 8, input lanes per beat (power of 2, 2..16); DW, 20, signed lane width; BW, 32, signed bias width; OW, 24, signed output width; ACCW, 40, signed accumulator width (>= BW+1 and >= DW+log2(NCH)+4).
REQ-002 Ports (name, direction, width, meaning): sclk, in, 1, the single clock; all logic is rising-edge.
REQ-003 s_rst_n, in, 1, reset; asynchronous, active-low.
REQ-004 in_valid, in, 1, beat qualifier; in_first, in, 1, first beat of an accumulation; in_last, in, 1, last beat of an accumulation.
REQ-005 in_data, in, NCH*DW, packed signed lanes, lane k at bits [k*DW +: DW].
REQ-006 bias, in, BW, signed; bias_enable, in, 1; both sampled on the in_first beat.
REQ-007 shift, in, 5, requantise right-shift; relu_en, in, 1; both sampled on the in_last beat.
REQ-008 err_clr, in, 1, clears seq_err.
REQ-009 out_valid, out, 1; out_data, out, OW, signed result; out_sat, out, 1, result clipped; seq_err, out, 1, sticky framing error.

Function
REQ-010 Adder tree: L = log2(NCH) registered pairwise stages, each stage sign-extending its operands by 1 bit; the tree is not stalled; in_valid and the sideband fields travel with the data as a valid pipe.
REQ-011 Accumulate stage (1 register, after the tree): FSM states IDLE and ACCUM.
REQ-012 IDLE with first beat: acc <= sum + (bias_enable ? bias : 0), sign-extended to ACCW; -> ACCUM, or remain IDLE if last is also set.
REQ-013 ACCUM with non-first beat: acc <= acc + sum; on last -> IDLE.
REQ-014 ACCUM with first beat: the open accumulation is discarded, acc restarts per REQ-012, and seq_err is set.
REQ-015 IDLE with non-first beat: the beat is dropped, acc is unchanged, and seq_err is set.
REQ-016 The accumulator saturates at the ACCW signed limits and never wraps; saturation sets the out_sat sticky flag for the current accumulation.
REQ-017 Output stage (1 register) fires on the last beat: add round term 2^(shift-1) when shift>0, arithmetic right-shift by shift, apply ReLU (negative -> 0) if relu_en, then saturate to the OW signed range.
REQ-018 out_sat = 1 if REQ-016 or the OW clip occurred for this result.
REQ-019 out_valid is a 1-cycle pulse; out_data and out_sat hold their value until the next out_valid.
REQ-020 Latency: an in_last beat accepted at cycle 0 -> out_valid at cycle L+2; throughput is 1 beat per cycle with no bubbles.
REQ-021 in_valid=0 cycles insert bubbles only; the FSM and acc hold their values.
REQ-022 seq_err is sticky; err_clr clears it, and a simultaneous new error wins (seq_err stays 1).

Reset
REQ-023 On s_rst_n low, asynchronously: all pipe valids 0, FSM IDLE, acc 0, out_valid 0, out_data 0, out_sat 0, seq_err 0.
REQ-024 Reset mid-accumulation discards all in-flight beats; no out_valid is produced for them.

Structure
REQ-025 A shared package holds the FSM state typedef, the default widths, and the saturate/round helper functions.
REQ-026 One sub-module, psum_add_tree (parametrised NCH, DW, valid pipe), is instantiated once; accumulate and output stages live in the top level.

Verification (NCH=8, DW=20, OW=24; L=3, latency 5)
REQ-027 Reset asserted with beats in flight -> all outputs 0 and no out_valid after release.
REQ-028 One beat with first=last=1, all lanes 1, bias=10, bias_enable=1, shift=0 -> out_data=18, out_sat=0, out_valid exactly 5 cycles later.
REQ-029 Three beats (first, mid, last), all lanes 100, bias_enable=0, shift=4, with one bubble between beats -> out_data=150 ((2400+8)>>4).
REQ-030 One first=last beat, all lanes -5 -> out_data=-40 with relu_en=0, and out_data=0 with relu_en=1.
REQ-031 Four beats, all lanes 524287, shift=0 -> out_data=8388607, out_sat=1.
REQ-032 Framing errors:
- non-first beat in IDLE -> seq_err=1, no out_valid;
- err_clr pulse -> seq_err=0;
- first beat while ACCUM -> seq_err=1 and the result equals the restarted accumulation only.
